priority_request_server: RTL

PRIORITY_REQUEST_SERVER -- requirements
Module: priority_request_server

---
 rtl/priority_request_server.sv | 111 +++++++++++
 1 files changed

// File: rtl/priority_request_server.sv
// rtl/priority_request_server.sv - pending-request register with a valid/ready grant offer FSM.
// Fixed lowest-index winner by default; define PRIORITY_REQUEST_SERVER_RR_EN for round-robin.
module priority_request_server #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req_set,
  input  logic [WIDTH-1:0]         req_clr,
  output logic [WIDTH-1:0]         pnd,
  output logic                     grt_vld,
  input  logic                     grt_rdy,
  output logic [$clog2(WIDTH)-1:0] grt_idx,
  output logic [WIDTH-1:0]         grt_oht
);
  localparam int IW = $clog2(WIDTH);
  localparam int NG = (WIDTH + SPLIT - 1) / SPLIT;

  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_nxt;

  logic             hs;
  logic             load;
  logic             drop;
  logic [WIDTH-1:0] pnd_nxt;
  logic [WIDTH-1:0] search;
  logic [IW-1:0]    win;

  // Two-level search: pick the lowest non-empty group of SPLIT lines, then the lowest line in it.
  function automatic logic [IW-1:0] first_set(input logic [WIDTH-1:0] v);
    int            grp;
    logic          hit;
    logic [IW-1:0] idx;
    grp = 0;
    for (int g = NG - 1; g >= 0; g--) begin
      hit = 1'b0;
      for (int i = 0; i < WIDTH; i++)
        if (v[i] && (i / SPLIT == g)) hit = 1'b1;
      if (hit) grp = g;
    end
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i] && (i / SPLIT == grp)) idx = IW'(i);
    return idx;
  endfunction

  assign hs      = grt_vld & grt_rdy;
  // The offered line ignores req_clr; only the handshake retires it, and req_set always wins.
  assign pnd_nxt = req_set | (pnd & ~(req_clr & ~grt_oht) & ~(hs ? grt_oht : '0));
  assign search  = pnd & ~grt_oht;
  assign grt_vld = (state == OFFER);

`ifdef PRIORITY_REQUEST_SERVER_RR_EN
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    base;
  logic [WIDTH-1:0] rot;

  // On a back-to-back handshake the pointer is being advanced this edge, so search from it directly.
  assign base = (state == OFFER) ? grt_idx + IW'(1) : rr_ptr;
  assign rot  = (search >> base) | (search << (WIDTH - int'(base)));
  assign win  = first_set(rot) + base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rr_ptr <= '0;
    else if (hs) rr_ptr <= grt_idx + IW'(1);
  end
`else
  assign win = first_set(search);
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: if (|pnd) begin
        state_nxt = OFFER;
        load      = 1'b1;
      end
      OFFER: if (grt_rdy) begin
        if (|search) begin
          load = 1'b1;
        end else begin
          state_nxt = IDLE;
          drop      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pnd     <= '0;
      grt_idx <= '0;
      grt_oht <= '0;
    end else begin
      state <= state_nxt;
      pnd   <= pnd_nxt;
      if (load) begin
        grt_idx <= win;
        grt_oht <= WIDTH'(1) << win;
      end else if (drop) begin
        grt_idx <= '0;
        grt_oht <= '0;
      end
    end
  end
endmodule
